wdi_kick_gen: RTL and testbench
===============================

Name: wdi_kick_gen

Overview:
- Watchdog-kick generator feeding the wdi input of the reset controller.
- Releases wdi (high-Z) while in reset. After a startup delay it drives a square wave on wdi, toggling every HALF_MS.
- Software must supply a heartbeat. If the heartbeat stops, or software requests it, toggling freezes so the external watchdog times out and asserts wdt_rst_n.

Parameters:
- PRESC, 1000: clk cycles per 1 ms tick (1 MHz clk).
- START_MS, 100: delay from enable to first drive of wdi.
- HALF_MS, 1000: ms between wdi toggles. Must be < downstream watchdog timeout (1600 ms).
- HB_TIMEOUT_MS, 3000: max ms between heartbeat pulses before starving the watchdog.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset (driven from the reset controller's rst_n)
- en  in  1  enable kicking; 0 releases wdi
- hb  in  1  heartbeat pulse, one clk wide, from software
- force_starve  in  1  pulse; stop kicking deliberately (software-initiated watchdog reset)
- wdi_o  out  1  wdi drive level
- wdi_oe  out  1  wdi output enable (top level: s_wdi = wdi_oe ? wdi_o : 1'bz)
- kick  out  1  one-cycle pulse on each toggle
- starve  out  1  high while in STARVE
- state  out  2  current state: OFF=0, WAIT=1, RUN=2, STARVE=3

Behaviour:
- Reset (rst_n=0 at posedge clk): state=OFF, wdi_o=0, wdi_oe=0, kick=0, starve=0; prescaler, ms_cnt and hb_cnt = 0. Reset mid-operation aborts immediately, with the same values one cycle later.
- Tick: prescaler counts 0..PRESC-1; tick=1 for the cycle it equals PRESC-1, then wraps. Prescaler and ms_cnt clear on entry to WAIT and RUN, so all timing is exact relative to state entry.
- OFF: wdi_oe=0. en=1 moves to WAIT next cycle.
- WAIT: wdi_oe=0. ms_cnt increments per tick. When it reaches START_MS, go to RUN. On that same edge: wdi_oe=1, wdi_o=0.
- RUN:
  - ms_cnt increments per tick. When it reaches HALF_MS: wdi_o inverts, kick=1 for one cycle, ms_cnt=0.
  - hb_cnt increments per tick and clears on hb=1.
  - hb_cnt reaching HB_TIMEOUT_MS, or force_starve=1, moves to STARVE.
- STARVE: wdi_oe=1, wdi_o frozen at its last value, starve=1, no kick. Exits only via reset or en=0.
- en=0 in any state: go to OFF next cycle. wdi_oe=0; wdi_o retains its value. en is sampled each cycle.
- Priority, per cycle: reset > en=0 > starve entry > toggle.
- Simultaneous events:
  - Starve condition and toggle in the same cycle: no toggle, no kick.
  - hb and hb timeout tick in the same cycle: hb wins, hb_cnt=0.
- Counters: 16 bits, compared with ==. Terminal values never exceed 65535. Parameters are checked at elaboration: all must be ≥1, HB_TIMEOUT_MS > HALF_MS.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro WDI_KICK_HB_CHECK_EN.
- Defined: heartbeat supervision as above.
- Undefined:
  - hb_cnt is removed and hb is ignored.
  - RUN exits to STARVE only on force_starve; otherwise it kicks indefinitely.
  - HB_TIMEOUT_MS is unused.

Decomposition:
- Package wdi_kick_pkg: state enum (OFF, WAIT, RUN, STARVE), CNT_W=16, and state-code localparams.
- One sub-module, wdi_kick_tick: PRESC prescaler with synchronous clear input and one-cycle tick output.

Test Plan:
All scenarios use PRESC=4, START_MS=5, HALF_MS=10, HB_TIMEOUT_MS=30, with hb pulsed every 80 clk unless stated.
- Startup:
  - Stimulus: rst_n=0 for 3 clk, then rst_n=1, en=1.
  - Required: state=WAIT 1 clk after en. wdi_oe rises with wdi_o=0 exactly 20 clk after WAIT entry.
  - Required: first kick/toggle 40 clk later, then toggles every 40 clk.
- Heartbeat timeout:
  - Stimulus: stop hb while in RUN.
  - Required: state=STARVE and starve=1 exactly 120 clk after the last hb.
  - Required: wdi_o frozen, no kick, wdi_oe stays 1.
- Forced starve:
  - Stimulus: force_starve pulsed on the same cycle as a scheduled toggle.
  - Required: STARVE entered, no toggle, no kick on that cycle.
- Disable:
  - Stimulus: en=0 during RUN.
  - Required: OFF and wdi_oe=0 next cycle.
  - Stimulus: en=1 again.
  - Required: WAIT, then RUN after 20 clk.
- Reset mid-RUN:
  - Stimulus: rst_n=0 for 1 clk.
  - Required: next cycle state=OFF and wdi_oe=wdi_o=kick=starve=0.
- Macro undefined:
  - Stimulus: no hb for 400 clk.
  - Required: remains in RUN, toggling every 40 clk.

Source files
------------

// File: rtl/wdi_kick_pkg.sv
// Shared types for the watchdog-kick generator.
// State codes, counter width and terminal-count helper.
package wdi_kick_pkg;

    localparam int CNT_W = 16;

    localparam logic [1:0] ST_OFF_C    = 2'd0;
    localparam logic [1:0] ST_WAIT_C   = 2'd1;
    localparam logic [1:0] ST_RUN_C    = 2'd2;
    localparam logic [1:0] ST_STARVE_C = 2'd3;

    typedef enum logic [1:0] {
        S_OFF    = ST_OFF_C,
        S_WAIT   = ST_WAIT_C,
        S_RUN    = ST_RUN_C,
        S_STARVE = ST_STARVE_C
    } wdi_state_e;

    typedef logic [CNT_W-1:0] cnt_t;

    // Counters compare against value-1 so they fire on the Nth event.
    function automatic cnt_t term(input int unsigned v);
        return cnt_t'(v - 1);
    endfunction

endpackage

// File: rtl/wdi_kick_tick.sv
// Millisecond prescaler for the watchdog-kick generator.
// Counts 0..PRESC-1, tick high on the last count; clr restarts phase.
module wdi_kick_tick
    import wdi_kick_pkg::*;
#(
    parameter int unsigned PRESC = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    if (PRESC < 1 || PRESC > 65536) begin : g_bad_presc
        $error("wdi_kick_tick: PRESC out of range");
    end

    cnt_t cnt;

    assign tick = (cnt == term(PRESC));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + cnt_t'(1);
        end
    end

endmodule

// File: rtl/wdi_kick_gen.sv
// Watchdog-kick generator: square wave on wdi while software is alive.
// Define WDI_KICK_HB_CHECK_EN to starve the watchdog on heartbeat loss.
module wdi_kick_gen
    import wdi_kick_pkg::*;
#(
    parameter int unsigned PRESC         = 1000,
    parameter int unsigned START_MS      = 100,
    parameter int unsigned HALF_MS       = 1000,
    parameter int unsigned HB_TIMEOUT_MS = 3000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       hb,
    input  logic       force_starve,
    output logic       wdi_o,
    output logic       wdi_oe,
    output logic       kick,
    output logic       starve,
    output logic [1:0] state
);

    if (PRESC < 1 || START_MS < 1 || HALF_MS < 1 || HB_TIMEOUT_MS < 1)
    begin : g_bad_zero
        $error("wdi_kick_gen: parameters must be >= 1");
    end

    if (START_MS > 65536 || HALF_MS > 65536 || HB_TIMEOUT_MS > 65536)
    begin : g_bad_wide
        $error("wdi_kick_gen: terminal count exceeds counter width");
    end

    if (HB_TIMEOUT_MS <= HALF_MS) begin : g_bad_hb
        $error("wdi_kick_gen: HB_TIMEOUT_MS must exceed HALF_MS");
    end

    wdi_state_e st;
    cnt_t       ms_cnt;
    logic       tick;
    logic       tick_clr;
    logic       wait_done;
    logic       half_done;
    logic       starve_hit;

    assign state = st;

    assign wait_done = tick && (ms_cnt == term(START_MS));
    assign half_done = tick && (ms_cnt == term(HALF_MS));

    // Restart the ms phase on the edge that enters WAIT or RUN.
    assign tick_clr = en && ((st == S_OFF) ||
                             (st == S_WAIT && wait_done));

    wdi_kick_tick #(
        .PRESC (PRESC)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

`ifdef WDI_KICK_HB_CHECK_EN
    cnt_t hb_cnt;
    logic hb_expire;

    // A heartbeat on the expiry tick still counts as alive.
    assign hb_expire  = tick && !hb &&
                        (hb_cnt == term(HB_TIMEOUT_MS));
    assign starve_hit = force_starve || hb_expire;

    always_ff @(posedge clk) begin
        if (!rst_n || !en || st != S_RUN || hb) begin
            hb_cnt <= '0;
        end else if (tick) begin
            hb_cnt <= hb_cnt + cnt_t'(1);
        end
    end
`else
    logic hb_unused;

    assign hb_unused  = hb;
    assign starve_hit = force_starve;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st     <= S_OFF;
            wdi_o  <= 1'b0;
            wdi_oe <= 1'b0;
            kick   <= 1'b0;
            starve <= 1'b0;
            ms_cnt <= '0;
        end else begin
            kick <= 1'b0;
            if (!en) begin
                st     <= S_OFF;
                wdi_oe <= 1'b0;
                starve <= 1'b0;
                ms_cnt <= '0;
            end else begin
                unique case (st)
                    S_OFF: begin
                        st     <= S_WAIT;
                        ms_cnt <= '0;
                    end
                    S_WAIT: begin
                        if (wait_done) begin
                            st     <= S_RUN;
                            wdi_oe <= 1'b1;
                            wdi_o  <= 1'b0;
                            ms_cnt <= '0;
                        end else if (tick) begin
                            ms_cnt <= ms_cnt + cnt_t'(1);
                        end
                    end
                    S_RUN: begin
                        // Starving takes the edge even when a toggle is due.
                        if (starve_hit) begin
                            st     <= S_STARVE;
                            starve <= 1'b1;
                        end else if (half_done) begin
                            wdi_o  <= ~wdi_o;
                            kick   <= 1'b1;
                            ms_cnt <= '0;
                        end else if (tick) begin
                            ms_cnt <= ms_cnt + cnt_t'(1);
                        end
                    end
                    S_STARVE: begin
                        wdi_oe <= 1'b1;
                        starve <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_wdi_kick_gen.sv
// Bench for wdi_kick_gen: directed scenarios plus random traffic
// checked against a state-age arithmetic model.
module tb_wdi_kick_gen;

    localparam int P   = 4;
    localparam int SM  = 5;
    localparam int HM  = 10;
    localparam int HBT = 30;
`ifdef WDI_KICK_HB_CHECK_EN
    localparam bit HBCHK = 1'b1;
`else
    localparam bit HBCHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       hb = 1'b0;
    logic       force_starve = 1'b0;
    logic       wdi_o;
    logic       wdi_oe;
    logic       kick;
    logic       starve;
    logic [1:0] state;

    int total = 0;
    int bad = 0;

    wdi_kick_gen #(
        .PRESC         (P),
        .START_MS      (SM),
        .HALF_MS       (HM),
        .HB_TIMEOUT_MS (HBT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .hb           (hb),
        .force_starve (force_starve),
        .wdi_o        (wdi_o),
        .wdi_oe       (wdi_oe),
        .kick         (kick),
        .starve       (starve),
        .state        (state)
    );

    always #5 clk = ~clk;

    // Model: age = cycles spent in the current state (0 on entry).
    typedef struct {
        int st;
        int age;
        int hbref;
        bit wo;
        bit oe;
        bit kick;
        bit starve;
    } mdl_t;

    mdl_t m = '{st: 0, age: 0, hbref: -1, wo: 1'b0, oe: 1'b0,
                kick: 1'b0, starve: 1'b0};

    // Number of ms ticks in RUN/WAIT ages 0..n.
    function automatic int ftk(input int n);
        return (n + 1) / P;
    endfunction

    function automatic mdl_t model_next(input mdl_t c, input bit r,
                                        input bit e, input bit h,
                                        input bit f);
        mdl_t n;
        bit   tk;
        bit   to;
        n = c;
        n.kick = 1'b0;
        n.age = c.age + 1;
        if (!r) begin
            n = '{st: 0, age: 0, hbref: -1, wo: 1'b0, oe: 1'b0,
                  kick: 1'b0, starve: 1'b0};
        end else if (!e) begin
            if (c.st != 0) n.age = 0;
            n.st = 0;
            n.oe = 1'b0;
            n.starve = 1'b0;
        end else begin
            case (c.st)
                0: begin
                    n.st = 1;
                    n.age = 0;
                end
                1: begin
                    if (c.age == SM * P - 1) begin
                        n.st = 2;
                        n.age = 0;
                        n.hbref = -1;
                        n.oe = 1'b1;
                        n.wo = 1'b0;
                    end
                end
                2: begin
                    tk = (c.age % P) == P - 1;
                    to = HBCHK && tk && !h &&
                         (ftk(c.age) - ftk(c.hbref) == HBT);
                    if (f || to) begin
                        n.st = 3;
                        n.starve = 1'b1;
                    end else begin
                        if (h) n.hbref = c.age;
                        if (c.age % (HM * P) == HM * P - 1) begin
                            n.wo = !c.wo;
                            n.kick = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        return n;
    endfunction

    always @(posedge clk) begin
        m <= model_next(m, rst_n, en, hb, force_starve);
    end

    function automatic logic [5:0] dut_vec();
        return {state, wdi_o, wdi_oe, kick, starve};
    endfunction

    function automatic logic [5:0] mdl_vec();
        return {2'(m.st), m.wo, m.oe, m.kick, m.starve};
    endfunction

    function automatic bit hb_due();
        return (m.st == 2) && (m.age % 80 == 3);
    endfunction

    task automatic cyc(input bit h, input bit f);
        hb = h;
        force_starve = f;
        @(negedge clk);
        hb = 1'b0;
        force_starve = 1'b0;
    endtask

    task automatic goto_run(output bit ok);
        en = 1'b0;
        cyc(1'b0, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 60 && state != 2'd2; i++) begin
            cyc(1'b0, 1'b0);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL goto_run_model: got %b want %b",
                         dut_vec(), mdl_vec());
            end
        end
        ok = (state == 2'd2);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0);
            total++;
            if (dut_vec() !== 6'b0) begin
                bad++;
                $display("FAIL reset_outputs: got %b want %b",
                         dut_vec(), 6'b0);
            end
        end
    endtask

    task automatic test_startup();
        int n;
        bit exp_wo;
        rst_n = 1'b1;
        en = 1'b1;
        cyc(1'b0, 1'b0);
        total++;
        if (state !== 2'd1) begin
            bad++;
            $display("FAIL wait_entry: got %0d want 1", state);
        end
        n = 0;
        while (wdi_oe !== 1'b1 && n < 100) begin
            cyc(1'b0, 1'b0);
            n++;
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL startup_model: got %b want %b",
                         dut_vec(), mdl_vec());
            end
        end
        total++;
        if (n !== 20 || wdi_o !== 1'b0 || state !== 2'd2) begin
            bad++;
            $display("FAIL oe_rise: got %0d clk wdi_o=%b want 20 clk wdi_o=0",
                     n, wdi_o);
        end
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                cyc(hb_due(), 1'b0);
                n++;
                total++;
                if (dut_vec() !== mdl_vec()) begin
                    bad++;
                    $display("FAIL kick_model: got %b want %b",
                             dut_vec(), mdl_vec());
                end
            end while (kick !== 1'b1 && n < 100);
            exp_wo = (k % 2 == 0);
            total++;
            if (n !== 40 || wdi_o !== exp_wo) begin
                bad++;
                $display("FAIL kick_period: got %0d clk wdi_o=%b want 40 clk wdi_o=%b",
                         n, wdi_o, exp_wo);
            end
        end
    endtask

    task automatic test_hb_timeout();
        int   n;
        logic w;
        for (int i = 0; i < 8 && (m.age % P) != P - 1; i++) begin
            cyc(1'b0, 1'b0);
        end
        cyc(1'b1, 1'b0);
        n = 0;
        while (starve !== 1'b1 && n < 200) begin
            cyc(1'b0, 1'b0);
            n++;
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL hb_model: got %b want %b",
                         dut_vec(), mdl_vec());
            end
        end
        total++;
        if (n !== 120 || state !== 2'd3) begin
            bad++;
            $display("FAIL hb_timeout: got %0d clk state=%0d want 120 clk state=3",
                     n, state);
        end
        w = wdi_o;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b0, 1'b0);
            total++;
            if (dut_vec() !== {2'd3, w, 3'b101}) begin
                bad++;
                $display("FAIL starve_hold: got %b want %b",
                         dut_vec(), {2'd3, w, 3'b101});
            end
        end
    endtask

    task automatic test_no_hb();
        bit ok;
        goto_run(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL no_hb_reach_run: got state %0d want 2", state);
        end
        for (int i = 1; i <= 400; i++) begin
            cyc(1'b0, 1'b0);
            total++;
            if (state !== 2'd2 || kick !== (i % 40 == 0)) begin
                bad++;
                $display("FAIL no_hb_run: cycle %0d got state=%0d kick=%b want 2 %b",
                         i, state, kick, (i % 40 == 0));
            end
        end
    endtask

    task automatic test_force_starve();
        bit   ok;
        logic w;
        goto_run(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL fs_reach_run: got state %0d want 2", state);
        end
        for (int i = 0; i < 100 &&
             !(m.st == 2 && m.age % 40 == 39); i++) begin
            cyc(hb_due(), 1'b0);
        end
        w = wdi_o;
        cyc(1'b0, 1'b1);
        total++;
        if (dut_vec() !== {2'd3, w, 3'b101}) begin
            bad++;
            $display("FAIL force_starve: got %b want %b",
                     dut_vec(), {2'd3, w, 3'b101});
        end
        cyc(1'b0, 1'b0);
        total++;
        if (dut_vec() !== mdl_vec()) begin
            bad++;
            $display("FAIL force_starve_model: got %b want %b",
                     dut_vec(), mdl_vec());
        end
    endtask

    task automatic test_disable();
        bit   ok;
        logic w;
        goto_run(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL dis_reach_run: got state %0d want 2", state);
        end
        for (int i = 0; i < 50; i++) cyc(hb_due(), 1'b0);
        w = wdi_o;
        en = 1'b0;
        cyc(1'b0, 1'b0);
        total++;
        if (dut_vec() !== {2'd0, w, 3'b000}) begin
            bad++;
            $display("FAIL disable: got %b want %b",
                     dut_vec(), {2'd0, w, 3'b000});
        end
        en = 1'b1;
        cyc(1'b0, 1'b0);
        total++;
        if (state !== 2'd1 || wdi_oe !== 1'b0) begin
            bad++;
            $display("FAIL reenable_wait: got %0d oe=%b want 1 oe=0",
                     state, wdi_oe);
        end
        for (int i = 0; i < 19; i++) cyc(1'b0, 1'b0);
        total++;
        if (state !== 2'd1) begin
            bad++;
            $display("FAIL reenable_early: got %0d want 1", state);
        end
        cyc(1'b0, 1'b0);
        total++;
        if (state !== 2'd2 || wdi_oe !== 1'b1 || wdi_o !== 1'b0) begin
            bad++;
            $display("FAIL reenable_run: got %0d oe=%b o=%b want 2 1 0",
                     state, wdi_oe, wdi_o);
        end
    endtask

    task automatic test_reset_mid_run();
        for (int i = 0; i < 45; i++) cyc(hb_due(), 1'b0);
        total++;
        if (wdi_o !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_level: got %b want 1", wdi_o);
        end
        rst_n = 1'b0;
        cyc(1'b0, 1'b0);
        total++;
        if (dut_vec() !== 6'b0) begin
            bad++;
            $display("FAIL reset_mid_run: got %b want %b",
                     dut_vec(), 6'b0);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit h;
        bit f;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 499) != 0);
            en = ($urandom_range(0, 399) != 0);
            h = ($urandom_range(0, 59) == 0);
            f = ($urandom_range(0, 799) == 0);
            cyc(h, f);
            total++;
            if (dut_vec() !== mdl_vec()) begin
                bad++;
                $display("FAIL random_model: cycle %0d got %b want %b",
                         i, dut_vec(), mdl_vec());
            end
        end
        rst_n = 1'b1;
        en = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_startup();
`ifdef WDI_KICK_HB_CHECK_EN
        test_hb_timeout();
`else
        test_no_hb();
`endif
        test_force_starve();
        test_disable();
        test_reset_mid_run();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL sim_timeout: got no finish want finish");
        $fatal(1, "simulation time limit");
    end

endmodule
